// File: rtl/sipo_deser_pkg.sv
// Shared types and helpers for the sipo_deser serial-in/parallel-out receiver.
// Contents:
//   out_state_t : output-side state (EMPTY = no word held, FULL = word held)
//   cnt_width() : bit-counter width, $clog2(width) with a floor of 1
package sipo_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Parallel word handshake between the deserializer and its consumer.
// Signals:
//   pout   : completed word (driven by master)
//   pvalid : pout holds an unconsumed word (driven by master)
//   pready : consumer accepts pout when pvalid=1 (driven by slave)
// Modports: master = deserializer side, slave = consumer side.
interface sipo_deser_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] pout;
  logic             pvalid;
  logic             pready;

  modport master (output pout, output pvalid, input pready);
  modport slave  (input pout, input pvalid, output pready);

endinterface

// File: rtl/sipo_deser_shift_core.sv
// Shift register and bit counter for sipo_deser.
// Ports:
//   clk, rst       : clock, async active-high reset
//   sclr           : synchronous clear of framing state
//   sin, sin_en    : serial bit and its sample strobe
//   word           : shift contents including the current sin bit (valid with done)
//   done           : combinational; this edge samples the last bit of a word
//   bit_cnt        : bits collected in the current partial word
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;

  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST) shreg_next = {shreg[WIDTH-2:0], sin};
    else           shreg_next = {sin, shreg[WIDTH-1:1]};
  end

  assign word = shreg_next;
  assign done = sin_en && (bit_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sclr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sin_en) begin
      if (done) begin
        // completed word leaves via `word`; start the next one empty
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        shreg   <= shreg_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer, receive end of the PISO serial link.
// Collects WIDTH bits per word and presents each word on a registered port
// with a valid/ready handshake; a word completed while the previous one is
// still unconsumed is dropped and flagged on the sticky overrun output.
// Ports:
//   clk, rst    : clock, async active-high reset
//   sclr        : synchronous clear (framing, pvalid, overrun; pout kept)
//   sin, sin_en : serial bit and its sample strobe
//   pbus        : parallel handshake (pout, pvalid out; pready in)
//   overrun     : sticky dropped-word flag
//   bit_cnt     : bits collected in the current partial word
//
// Output FSM:
//   state | meaning
//   EMPTY | no word held, pvalid=0
//   FULL  | pout holds an unconsumed word, pvalid=1
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclr,
  input  logic                         sin,
  input  logic                         sin_en,
  sipo_deser_if.master                 pbus,
  output logic                         overrun,
  output logic [cnt_width(WIDTH)-1:0]  bit_cnt
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] word;
  logic             done;
  out_state_t       state_q;
  out_state_t       state_d;
  logic             load;
  logic             ovr_set;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (CW)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .sclr    (sclr),
    .sin     (sin),
    .sin_en  (sin_en),
    .word    (word),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      EMPTY: begin
        if (done) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (done) begin
          // an accept on the completion edge frees the slot for the new word
          if (pbus.pready) load    = 1'b1;
          else             ovr_set = 1'b1;
        end else if (pbus.pready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      pbus.pout <= '0;
      overrun   <= 1'b0;
    end else if (sclr) begin
      state_q   <= EMPTY;
      overrun   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load)    pbus.pout <= word;
      if (ovr_set) overrun   <= 1'b1;
    end
  end

  assign pbus.pvalid = (state_q == FULL);

endmodule
